// File: rtl/blocking_out_fifo_mc.sv
// blocking_out_fifo_mc: CH independent blocking output ports, each backed by a DEPTH-entry FIFO,
// fed from one channel-addressed producer port with blocking or non-blocking writes.
module blocking_out_fifo_mc #(
   parameter int DATA_W = 32,
   parameter int CH = 4,
   parameter int DEPTH = 4,
   localparam int CH_W = (CH > 1) ? $clog2(CH) : 1,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_valid,
   input  logic                 wr_nb,
   input  logic [CH_W-1:0]      wr_ch,
   input  logic [DATA_W-1:0]    wr_data,
   output logic                 wr_ready,
   output logic                 nb_result,
   output logic                 nb_result_valid,
   output logic                 wr_err,
   output logic [CH*DATA_W-1:0] out_data,
   input  logic [CH-1:0]        out_sync,
   output logic [CH-1:0]        out_notify,
   output logic [CH*LW-1:0]     out_level
);
   logic [DATA_W-1:0] mem_q [CH][DEPTH];
   logic [AW-1:0] rd_ptr_q [CH];
   logic [AW-1:0] rd_ptr_d [CH];
   logic [AW-1:0] wr_ptr_q [CH];
   logic [AW-1:0] wr_ptr_d [CH];
   logic [LW-1:0] level_q [CH];
   logic [LW-1:0] level_d [CH];
   logic [CH-1:0] full, push_c, pop_c;
   logic ch_ok, push;
   logic [CH_W-1:0] ch_idx;
   logic nb_result_q, nb_valid_q, wr_err_q;

   // full is registered state, so a same-cycle pop never frees a slot for a blocking write
   always_comb begin
      ch_ok = 32'(wr_ch) < CH;
      ch_idx = ch_ok ? wr_ch : '0;
      for (int c = 0; c < CH; c++) full[c] = level_q[c] == LW'(DEPTH);
      wr_ready = wr_nb | ~ch_ok | ~full[ch_idx];
      push = wr_valid & ch_ok & ~full[ch_idx];
      out_data = '0;
      out_level = '0;
      out_notify = '0;
      for (int c = 0; c < CH; c++) begin
         push_c[c] = push & (ch_idx == CH_W'(c));
         out_notify[c] = level_q[c] != '0;
         pop_c[c] = out_notify[c] & out_sync[c];
         wr_ptr_d[c] = wr_ptr_q[c] + AW'(push_c[c]);
         rd_ptr_d[c] = rd_ptr_q[c] + AW'(pop_c[c]);
         level_d[c] = level_q[c] + LW'(push_c[c]) - LW'(pop_c[c]);
         out_data[c*DATA_W +: DATA_W] = out_notify[c] ? mem_q[c][rd_ptr_q[c]] : '0;
         out_level[c*LW +: LW] = level_q[c];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < CH; c++) begin
            for (int e = 0; e < DEPTH; e++) mem_q[c][e] <= '0;
            rd_ptr_q[c] <= '0;
            wr_ptr_q[c] <= '0;
            level_q[c] <= '0;
         end
         nb_result_q <= 1'b0;
         nb_valid_q <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (push_c[c]) mem_q[c][wr_ptr_q[c]] <= wr_data;
            rd_ptr_q[c] <= rd_ptr_d[c];
            wr_ptr_q[c] <= wr_ptr_d[c];
            level_q[c] <= level_d[c];
         end
         if (wr_valid & wr_nb) nb_result_q <= push;
         nb_valid_q <= wr_valid & wr_nb;
         wr_err_q <= wr_valid & ~ch_ok;
      end
   end

   assign nb_result = nb_result_q;
   assign nb_result_valid = nb_valid_q;
   assign wr_err = wr_err_q;
endmodule

// File: tb/tb_blocking_out_fifo_mc.sv
// tb_blocking_out_fifo_mc: directed checks of a 4-channel instance plus a 3-channel instance
// used for the out-of-range channel cases.
module tb_blocking_out_fifo_mc;
   logic clk, rst, wr_valid, wr_nb;
   logic [1:0] wr_ch;
   logic [31:0] wr_data;
   logic [3:0] out_sync;
   logic wr_ready, nb_result, nb_result_valid, wr_err;
   logic [127:0] out_data;
   logic [3:0] out_notify;
   logic [11:0] out_level;
   logic wr_ready3, nb_result3, nb_valid3, wr_err3;
   logic [95:0] out_data3;
   logic [2:0] out_notify3;
   logic [8:0] out_level3;
   int n_chk = 0;
   int n_fail = 0;

   blocking_out_fifo_mc #(.DATA_W(32), .CH(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_nb(wr_nb), .wr_ch(wr_ch), .wr_data(wr_data),
      .wr_ready(wr_ready), .nb_result(nb_result), .nb_result_valid(nb_result_valid), .wr_err(wr_err),
      .out_data(out_data), .out_sync(out_sync), .out_notify(out_notify), .out_level(out_level));

   blocking_out_fifo_mc #(.DATA_W(32), .CH(3), .DEPTH(4)) dut3 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_nb(wr_nb), .wr_ch(wr_ch), .wr_data(wr_data),
      .wr_ready(wr_ready3), .nb_result(nb_result3), .nb_result_valid(nb_valid3), .wr_err(wr_err3),
      .out_data(out_data3), .out_sync(out_sync[2:0]), .out_notify(out_notify3), .out_level(out_level3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] lvl(input int c);
      return out_level[c*3 +: 3];
   endfunction

   function automatic logic [31:0] dat(input int c);
      return out_data[c*32 +: 32];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic nb, input logic [1:0] ch, input logic [31:0] d);
      wr_valid = 1'b1;
      wr_nb = nb;
      wr_ch = ch;
      wr_data = d;
   endtask

   initial begin
      rst = 1'b0;
      wr_valid = 1'b0;
      wr_nb = 1'b0;
      wr_ch = '0;
      wr_data = '0;
      out_sync = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_notify", 64'(out_notify), 0);
      chk("rst_level", 64'(out_level), 0);
      chk("rst_data", 64'(out_data[63:0]), 0);
      chk("rst_nb_result", 64'(nb_result), 0);
      chk("rst_wr_ready", 64'(wr_ready), 1);
      rst = 1'b1;
      step();
      chk("idle_notify", 64'(out_notify), 0);
      // single blocking write to ch2, held until sync
      wr(1'b0, 2'd2, 32'h11);
      #1 chk("a_wr_ready", 64'(wr_ready), 1);
      step();
      wr_valid = 1'b0;
      chk("a_notify", 64'(out_notify), 64'h4);
      chk("a_data2", 64'(dat(2)), 64'h11);
      chk("a_level2", 64'(lvl(2)), 1);
      step();
      chk("a_hold_data2", 64'(dat(2)), 64'h11);
      out_sync = 4'b0100;
      step();
      out_sync = '0;
      chk("a_pop_notify", 64'(out_notify), 0);
      chk("a_pop_level2", 64'(lvl(2)), 0);
      // fill ch1
      for (int i = 0; i < 4; i++) begin
         wr(1'b0, 2'd1, 32'hA0 + 32'(i));
         #1 chk("b_fill_ready", 64'(wr_ready), 1);
         step();
      end
      wr_data = 32'hA4;
      #1 chk("b_full_ready", 64'(wr_ready), 0);
      chk("b_full_level", 64'(lvl(1)), 4);
      step();
      chk("b_stall_level", 64'(lvl(1)), 4);
      out_sync = 4'b0010;
      #1 chk("b_pop_cycle_ready", 64'(wr_ready), 0);
      step();
      out_sync = '0;
      #1 chk("b_after_pop_level", 64'(lvl(1)), 3);
      chk("b_after_pop_ready", 64'(wr_ready), 1);
      chk("b_after_pop_head", 64'(dat(1)), 64'hA1);
      step();
      wr_valid = 1'b0;
      chk("b_refill_level", 64'(lvl(1)), 4);
      // non-blocking to full ch1, then to empty ch0
      wr(1'b1, 2'd1, 32'hBB);
      #1 chk("c_nb_full_ready", 64'(wr_ready), 1);
      step();
      wr_valid = 1'b0;
      chk("c_nb_full_valid", 64'(nb_result_valid), 1);
      chk("c_nb_full_result", 64'(nb_result), 0);
      chk("c_nb_full_level", 64'(lvl(1)), 4);
      step();
      chk("c_nb_valid_drop", 64'(nb_result_valid), 0);
      wr(1'b1, 2'd0, 32'hC0);
      step();
      wr_valid = 1'b0;
      chk("c_nb_ok_valid", 64'(nb_result_valid), 1);
      chk("c_nb_ok_result", 64'(nb_result), 1);
      chk("c_nb_ok_level0", 64'(lvl(0)), 1);
      chk("c_nb_ok_data0", 64'(dat(0)), 64'hC0);
      step();
      chk("c_nb_hold", 64'(nb_result), 1);
      // drain ch1 in FIFO order
      out_sync = 4'b0010;
      for (int i = 1; i < 5; i++) begin
         #1 chk("b_drain_order", 64'(dat(1)), 64'hA0 + 64'(i));
         step();
      end
      out_sync = '0;
      chk("b_drained_notify1", 64'(out_notify[1]), 0);
      // independent channels and simultaneous push/pop
      wr(1'b0, 2'd2, 32'h21);
      step();
      wr_data = 32'h22;
      step();
      wr(1'b0, 2'd3, 32'h31);
      out_sync = 4'b0001;
      step();
      chk("d_level0", 64'(lvl(0)), 0);
      chk("d_level3", 64'(lvl(3)), 1);
      chk("d_level2", 64'(lvl(2)), 2);
      wr(1'b0, 2'd2, 32'h23);
      out_sync = 4'b0100;
      #1 chk("d_pushpop_ready", 64'(wr_ready), 1);
      step();
      out_sync = '0;
      wr_valid = 1'b0;
      chk("d_pushpop_level2", 64'(lvl(2)), 2);
      chk("d_pushpop_head2", 64'(dat(2)), 64'h22);
      chk("d_level3_hold", 64'(lvl(3)), 1);
      wr(1'b0, 2'd0, 32'h01);
      step();
      wr(1'b0, 2'd1, 32'h02);
      step();
      wr_valid = 1'b0;
      chk("d_all_notify", 64'(out_notify), 64'hF);
      // asynchronous reset mid-stream
      #2 rst = 1'b0;
      #1 chk("e_async_notify", 64'(out_notify), 0);
      chk("e_async_level", 64'(out_level), 0);
      chk("e_async_data", 64'(out_data[127:64]), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      step();
      chk("e_post_rst_notify", 64'(out_notify), 0);
      chk("e_post_rst_level", 64'(out_level), 0);
      // invalid channel on the 3-channel instance
      wr(1'b0, 2'd3, 32'h77);
      #1 chk("f_bad_ready", 64'(wr_ready3), 1);
      step();
      wr_valid = 1'b0;
      chk("f_bad_err", 64'(wr_err3), 1);
      chk("f_bad_level", 64'(out_level3), 0);
      chk("f_good_err", 64'(wr_err), 0);
      step();
      chk("f_err_pulse", 64'(wr_err3), 0);
      wr(1'b1, 2'd0, 32'h55);
      step();
      wr_valid = 1'b0;
      chk("f_nb_ok", 64'(nb_result3), 1);
      chk("f_nb_ok_err", 64'(wr_err3), 0);
      wr(1'b1, 2'd3, 32'h66);
      #1 chk("f_nb_bad_ready", 64'(wr_ready3), 1);
      step();
      wr_valid = 1'b0;
      chk("f_nb_bad_result", 64'(nb_result3), 0);
      chk("f_nb_bad_valid", 64'(nb_valid3), 1);
      chk("f_nb_bad_err", 64'(wr_err3), 1);
      chk("f_nb_bad_level", 64'(out_level3), 64'h001);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
